mux16_select: RTL and testbench

- 16-to-1 single-bit selector. Picks one bit of a 16-bit input vector by a 4-bit index.
- Provides two outputs: an immediate combinational result and a registered copy with a valid strobe.
- Used wherever a single status or data bit must be picked out of a packed bus. The registered copy is for timing-critical consumers.

---
 rtl/mux16_select.sv | 83 ++++++++
 tb/tb_mux16_select.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mux16_select.sv
`default_nettype none
// ============================================================================
// Module   : mux16_select
// Purpose  : N-to-1 single-bit selector with a zero-latency combinational
//            result and a registered copy qualified by a one-cycle valid
//            strobe and an out-of-range select flag.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_select #(
  parameter int N_INPUTS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_INPUTS-1:0] in_data,
  input  logic [SEL_W-1:0]    sel,
  output logic                y_comb,
  output logic                y,
  output logic                y_valid,
  output logic                sel_err
);

  localparam int c_SEL_RANGE = 2 ** SEL_W;

  // The input vector is widened to the full select range with zero fill, so
  // an out-of-range index naturally reads 0 and a selected X/Z bit passes
  // straight through to the output.
  logic [c_SEL_RANGE-1:0] w_padded;
  logic                   w_sel_oor;
  logic                   w_y_comb;

  generate
    if (N_INPUTS < c_SEL_RANGE) begin : g_partial
      localparam logic [SEL_W:0] c_N_LIMIT = (SEL_W + 1)'(N_INPUTS);
      assign w_padded  = {{(c_SEL_RANGE - N_INPUTS){1'b0}}, in_data};
      assign w_sel_oor = ({1'b0, sel} >= c_N_LIMIT);
    end else begin : g_full
      // Every encodable index is a real input; the range flag can never rise.
      assign w_padded  = in_data;
      assign w_sel_oor = 1'b0;
    end
  endgenerate

  assign w_y_comb = w_padded[sel];
  assign y_comb   = w_y_comb;

  logic y_q, y_d;
  logic y_valid_q, y_valid_d;
  logic sel_err_q, sel_err_d;

  // Next-state: capture the selected bit and range flag on enable, else hold;
  // the valid strobe simply follows the enable.
  always_comb begin
    y_d       = y_q;
    sel_err_d = sel_err_q;
    y_valid_d = en;
    if (en) begin
      y_d       = w_y_comb;
      sel_err_d = w_sel_oor;
    end
  end

  // Output registers; reset clears them immediately, discarding any sample
  // that was about to be taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign sel_err = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux16_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux16_select
// Purpose  : Scoreboard bench for mux16_select, exercising a full 16-input
//            build and a 12-input build side by side from one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux16_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] in_data;
  logic [3:0]  sel;

  logic y_comb16, y16, y_valid16, sel_err16;
  logic y_comb12, y12, y_valid12, sel_err12;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic y16;
    logic e16;
    logic y12;
    logic e12;
  } exp_t;

  exp_t sb[$];

  mux16_select #(.N_INPUTS(16), .SEL_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in_data (in_data),
    .sel     (sel),
    .y_comb  (y_comb16),
    .y       (y16),
    .y_valid (y_valid16),
    .sel_err (sel_err16)
  );

  mux16_select #(.N_INPUTS(12), .SEL_W(4)) dut12 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .in_data (in_data[11:0]),
    .sel     (sel),
    .y_comb  (y_comb12),
    .y       (y12),
    .y_valid (y_valid12),
    .sel_err (sel_err12)
  );

  // 100 MHz style free-running clock
  always #5 clk = ~clk;

  // Reference: an index at or beyond the input count reads 0, otherwise the
  // bit at that position of the vector.
  function automatic logic ref_bit(input logic [15:0] d, input int s, input int n);
    logic [15:0] t;
    if (s >= n) return 1'b0;
    t = d >> s;
    return t[0];
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: apply inputs after the falling edge, record what the
  // next rising edge should capture, then check the combinational outputs.
  task automatic drive(input logic [15:0] d, input int s, input logic e);
    exp_t x;
    @(negedge clk);
    in_data = d;
    sel     = 4'(s);
    en      = e;
    if (e) begin
      x.y16 = ref_bit(d, s, 16);
      x.e16 = 1'b0;
      x.y12 = ref_bit(d, s, 12);
      x.e12 = (s >= 12);
      sb.push_back(x);
    end
    #1;
    check("y_comb16", y_comb16, ref_bit(d, s, 16));
    check("y_comb12", y_comb12, ref_bit(d, s, 12));
  endtask

  // Monitor: shortly after each rising edge, pop and compare when a valid
  // sample is presented; otherwise confirm the registered outputs held.
  logic h16 = 1'b0, he16 = 1'b0, h12 = 1'b0, he12 = 1'b0;
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (rst) begin
      h16 = 1'b0; he16 = 1'b0; h12 = 1'b0; he12 = 1'b0;
      check("rst_y16", y16, 1'b0);
      check("rst_valid16", y_valid16, 1'b0);
      check("rst_y12", y12, 1'b0);
      check("rst_err12", sel_err12, 1'b0);
    end else if (y_valid16) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got y_valid=1 expected 0 at %0t", $time);
      end else begin
        x = sb.pop_front();
        check("y16", y16, x.y16);
        check("sel_err16", sel_err16, x.e16);
        check("y12", y12, x.y12);
        check("sel_err12", sel_err12, x.e12);
        check("y_valid12", y_valid12, 1'b1);
        h16 = x.y16; he16 = x.e16; h12 = x.y12; he12 = x.e12;
      end
    end else begin
      if (sb.size() != 0) begin
        x = sb.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missing_valid: got y_valid=0 expected 1 at %0t", $time);
      end else begin
        check("hold_y16", y16, h16);
        check("hold_err16", sel_err16, he16);
        check("hold_y12", y12, h12);
        check("hold_err12", sel_err12, he12);
        check("y_valid12_low", y_valid12, 1'b0);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; in_data = 16'h0; sel = 4'd0;
    #1 rst = 1'b1;
    #1;
    check("init_y16", y16, 1'b0);
    check("init_valid16", y_valid16, 1'b0);
    check("init_err12", sel_err12, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Combinational select on two patterns
    drive(16'h674F, 5, 1'b0);
    drive(16'h674F, 12, 1'b0);
    drive(16'h674F, 8, 1'b0);
    drive(16'h674F, 3, 1'b0);
    drive(16'hA017, 0, 1'b0);
    drive(16'hA017, 5, 1'b0);
    drive(16'hA017, 10, 1'b0);
    drive(16'hA017, 15, 1'b0);

    // Registered sample, then a hold cycle
    drive(16'hA017, 15, 1'b1);
    drive(16'hA017, 15, 1'b0);

    // Back-to-back enables
    drive(16'hA017, 0, 1'b1);
    drive(16'hA017, 5, 1'b1);
    drive(16'hA017, 10, 1'b1);

    // Out-of-range on the 12-input build, then back in range
    drive(16'hA017, 13, 1'b1);
    drive(16'hA017, 11, 1'b1);
    drive(16'hA017, 13, 1'b1);
    drive(16'hA017, 13, 1'b0);

    // Asynchronous reset between edges with a sample about to be taken
    @(negedge clk);
    en = 1'b1;
    sel = 4'd15;
    #2 rst = 1'b1;
    #1;
    check("async_y16", y16, 1'b0);
    check("async_valid16", y_valid16, 1'b0);
    check("async_err12", sel_err12, 1'b0);
    check("async_ycomb16", y_comb16, ref_bit(in_data, 15, 16));
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(16'($urandom), int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    drive(16'h0000, 0, 1'b0);
    @(posedge clk);
    #2;
    check("sb_drained", (sb.size() == 0), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
